// File: rtl/av_pkg.sv
// Shared definitions for the AV layer compositor: pixel layout, fade states and layer map.
package av_pkg;

  localparam int AV_COLOR_W = 4;
  localparam int AV_RGB_W   = 3 * AV_COLOR_W;
  localparam int OPAQUE_BIT = AV_RGB_W;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIM_DOWN = 2'd1,
    PAUSED   = 2'd2,
    DIM_UP   = 2'd3
  } fade_state_e;

  localparam int LAYER_MENU    = 0;
  localparam int LAYER_SCORE   = 1;
  localparam int LAYER_STRING1 = 2;
  localparam int LAYER_STRING2 = 3;
  localparam int LAYER_STRING3 = 4;
  localparam int LAYER_STRING4 = 5;
  localparam int LAYER_STRING5 = 6;
  localparam int LAYER_STRING6 = 7;
  localparam int LAYER_COUNT   = 8;

  // Opaque flag sits directly above the {R,G,B} field of a layer word.
  function automatic int opaque_bit(input int color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/av_fade_ctrl.sv
// Pause synchroniser and frame-tick driven fade FSM producing the dim level.
module av_fade_ctrl
  import av_pkg::*;
#(
  parameter int FADE_LOG2 = 3,
  parameter int MAX_LEVEL = 6
) (
  input  logic                 clk65,
  input  logic                 reset,
  input  logic                 pause,
  input  logic                 tick,
  output logic [FADE_LOG2:0]   fade_level,
  output logic                 paused,
  output fade_state_e          state
);

  localparam int            LW      = FADE_LOG2 + 1;
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(MAX_LEVEL);

  logic [1:0]    sync_q;
  logic          pause_s;
  fade_state_e   state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          paused_q;

  assign pause_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      RUN:      if (pause_s) level_d = LVL_ONE;
      DIM_DOWN: level_d = pause_s ? level_q + LVL_ONE : level_q - LVL_ONE;
      PAUSED:   if (!pause_s) level_d = LVL_MAX - LVL_ONE;
      DIM_UP:   level_d = pause_s ? level_q + LVL_ONE : level_q - LVL_ONE;
      default:  level_d = level_q;
    endcase
    // State is derived from where the level lands, so a MAX_LEVEL of 1 or a
    // reversal at level 1 settles in the same transition.
    if (level_d == '0)          state_d = RUN;
    else if (level_d >= LVL_MAX) state_d = PAUSED;
    else if (pause_s)           state_d = DIM_DOWN;
    else                        state_d = DIM_UP;
  end

  always_ff @(posedge clk65) begin
    if (reset) begin
      sync_q   <= 2'b00;
      state_q  <= RUN;
      level_q  <= '0;
      paused_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pause};
      if (tick) begin
        state_q  <= state_d;
        level_q  <= level_d;
        paused_q <= (state_d == PAUSED);
      end
    end
  end

  assign fade_level = level_q;
  assign paused     = paused_q;
  assign state      = state_q;

endmodule

// File: rtl/av_layer_compositor.sv
// Priority overlay compositor with frame-synchronous enables and pause dimming;
// three-stage pipeline with sync/blank delayed to match.
module av_layer_compositor
  import av_pkg::*;
#(
  parameter int                    NUM_LAYERS       = LAYER_COUNT,
  parameter int                    COLOR_W          = AV_COLOR_W,
  parameter int                    MENU_LAYER       = LAYER_MENU,
  parameter int                    FADE_LOG2        = 3,
  parameter int                    MAX_LEVEL        = 6,
  parameter logic [NUM_LAYERS-1:0] EN_RESET         = '1,
  parameter bit                    VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                                   clk65,
  input  logic                                   reset,
  input  logic                                   hsync_in,
  input  logic                                   vsync_in,
  input  logic                                   blank_in,
  input  logic [NUM_LAYERS*(3*COLOR_W+1)-1:0]    layer_pixels,
  input  logic [3*COLOR_W-1:0]                   bg_pixel,
  input  logic [NUM_LAYERS-1:0]                  layer_en_in,
  input  logic                                   pause,
  output logic [3*COLOR_W-1:0]                   pixel,
  output logic                                   hsync_out,
  output logic                                   vsync_out,
  output logic                                   blank_out,
  output logic [FADE_LOG2:0]                     fade_level,
  output logic                                   paused
);

  localparam int   RGB_W     = 3 * COLOR_W;
  localparam int   LAY_W     = RGB_W + 1;
  localparam int   OPQ       = opaque_bit(COLOR_W);
  localparam int   PROD_W    = COLOR_W + FADE_LOG2 + 1;
  localparam logic SYNC_IDLE = VSYNC_ACTIVE_LOW;
  localparam logic VS_ACTIVE = ~SYNC_IDLE;
  localparam logic [FADE_LOG2:0] SCALE_ONE = {1'b1, {FADE_LOG2{1'b0}}};

  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0]   rgb,
                                               input logic [FADE_LOG2:0] lvl);
    logic [FADE_LOG2:0] scale;
    logic [PROD_W-1:0]  prod;
    logic [RGB_W-1:0]   res;
    scale = SCALE_ONE - lvl;
    res   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      prod = PROD_W'(rgb[ch*COLOR_W +: COLOR_W]) * PROD_W'(scale);
      res[ch*COLOR_W +: COLOR_W] = prod[FADE_LOG2 +: COLOR_W];
    end
    return res;
  endfunction

  logic [NUM_LAYERS*LAY_W-1:0] lay_p0;
  logic [RGB_W-1:0]            bg_p0;
  logic                        hs_p0, vs_p0, blank_p0;
  logic [RGB_W-1:0]            rgb_p1;
  logic                        menu_p1, hs_p1, vs_p1, blank_p1;
  logic [RGB_W-1:0]            pix_p2;
  logic                        hs_p2, vs_p2, blank_p2;
  logic [NUM_LAYERS-1:0]       active_en_q;
  logic [RGB_W-1:0]            sel_rgb_d;
  logic                        sel_menu_d;
  logic                        frame_tick;
  fade_state_e                 fade_state;

  // vs_p1 holds the previous registered vsync, so this fires once per assertion edge.
  assign frame_tick = (vs_p0 == VS_ACTIVE) && (vs_p1 != VS_ACTIVE);

  av_fade_ctrl #(
    .FADE_LOG2 (FADE_LOG2),
    .MAX_LEVEL (MAX_LEVEL)
  ) u_fade (
    .clk65      (clk65),
    .reset      (reset),
    .pause      (pause),
    .tick       (frame_tick),
    .fade_level (fade_level),
    .paused     (paused),
    .state      (fade_state)
  );

  // Highest index first so the lowest-indexed eligible layer wins.
  always_comb begin
    sel_rgb_d  = bg_p0;
    sel_menu_d = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (lay_p0[i*LAY_W + OPQ] && active_en_q[i] &&
          !((i == MENU_LAYER) && (fade_state == RUN))) begin
        sel_rgb_d  = lay_p0[i*LAY_W +: RGB_W];
        sel_menu_d = (i == MENU_LAYER);
      end
    end
  end

  always_ff @(posedge clk65) begin
    if (reset) begin
      lay_p0      <= '0;
      bg_p0       <= '0;
      hs_p0       <= SYNC_IDLE;
      vs_p0       <= SYNC_IDLE;
      blank_p0    <= 1'b1;
      rgb_p1      <= '0;
      menu_p1     <= 1'b0;
      hs_p1       <= SYNC_IDLE;
      vs_p1       <= SYNC_IDLE;
      blank_p1    <= 1'b1;
      pix_p2      <= '0;
      hs_p2       <= SYNC_IDLE;
      vs_p2       <= SYNC_IDLE;
      blank_p2    <= 1'b1;
      active_en_q <= EN_RESET;
    end else begin
      // S1: capture inputs
      lay_p0   <= layer_pixels;
      bg_p0    <= bg_pixel;
      hs_p0    <= hsync_in;
      vs_p0    <= vsync_in;
      blank_p0 <= blank_in;
      // S2: priority select
      rgb_p1   <= sel_rgb_d;
      menu_p1  <= sel_menu_d;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      blank_p1 <= blank_p0;
      // S3: blank / dim
      pix_p2   <= blank_p1 ? '0 : (menu_p1 ? rgb_p1 : dim_rgb(rgb_p1, fade_level));
      hs_p2    <= hs_p1;
      vs_p2    <= vs_p1;
      blank_p2 <= blank_p1;
      if (frame_tick) active_en_q <= layer_en_in;
    end
  end

  assign pixel     = pix_p2;
  assign hsync_out = hs_p2;
  assign vsync_out = vs_p2;
  assign blank_out = blank_p2;

endmodule

// File: doc/av_layer_compositor.md
Name: av_layer_compositor

Overview:
Parametrised successor to the fixed menu/score/string/background integrator in the AV path. Composites NUM_LAYERS priority-ordered overlay layers over a background pixel at 65 MHz, delaying sync/blank to match. Adds frame-synchronous layer enables, a menu layer gated by pause, and a per-frame pause fade that dims game layers. Sits between the xvga timing generator plus the per-layer graphics generators and the VGA pins.

Parameters:
NUM_LAYERS, 8, number of overlay layers; index 0 is highest priority
COLOR_W, 4, bits per colour channel; pixel RGB width = 3*COLOR_W
MENU_LAYER, 0, layer index treated as the menu: never dimmed, visible only when fade state != RUN
FADE_LOG2, 3, dim scale denominator is 2**FADE_LOG2
MAX_LEVEL, 6, fade level reached when fully paused; must be <= 2**FADE_LOG2
EN_RESET, all ones, reset value of the active layer-enable register
VSYNC_ACTIVE_LOW, 1, vsync polarity; the frame tick fires on the assertion edge

Ports:
clk65  in  1  pixel clock, 65 MHz
reset  in  1  synchronous, active-high reset
hsync_in  in  1  from xvga
vsync_in  in  1  from xvga
blank_in  in  1  from xvga
layer_pixels  in  NUM_LAYERS*(3*COLOR_W+1)  per layer, MSB = opaque flag, rest = {R,G,B}; layer i occupies slice i
bg_pixel  in  3*COLOR_W  background colour, always opaque
layer_en_in  in  NUM_LAYERS  requested layer enables; applied at the next frame tick
pause  in  1  pause request; asynchronous to clk65
pixel  out  3*COLOR_W  composited {R,G,B} to VGA
hsync_out  out  1  hsync_in delayed 3 cycles
vsync_out  out  1  vsync_in delayed 3 cycles
blank_out  out  1  blank_in delayed 3 cycles
fade_level  out  FADE_LOG2+1  current dim level, 0..MAX_LEVEL
paused  out  1  high while the fade state is PAUSED

Behaviour:
- Reset values: pixel=0; blank_out=1; hsync_out/vsync_out at the inactive level; fade_level=0; paused=0; FSM=RUN; active enables=EN_RESET; synchroniser and pipeline flops cleared. Reset mid-frame takes effect on the next edge, with no partial-frame state retained.
- pause passes through a 2-flop synchroniser (pause_s) before use.
- Frame tick: registered vsync_in transitions from inactive to active level. One cycle wide.
- On a tick, active_en <= layer_en_in. Never updated mid-frame.
- Pipeline, fixed latency 3 cycles, no stalls:
  - S1: register layer_pixels, bg_pixel, and the sync/blank signals.
  - S2: select the lowest index i with opaque_i & active_en[i] & !(i==MENU_LAYER & state==RUN). Otherwise select bg. Record whether the selection is the menu layer.
  - S3: if blank, pixel=0. Else if the selection is menu, pixel=raw. Else apply dimming per channel: c_out = (c * (2**FADE_LOG2 - fade_level)) >> FADE_LOG2. Truncating; intermediate width COLOR_W+FADE_LOG2+1.
- Fade FSM advances only on frame ticks, sampling pause_s:
  - RUN: pause_s=1 -> DIM_DOWN with level 1.
  - DIM_DOWN: pause_s=0 -> DIM_UP with level-1. Else level+1; reaching MAX_LEVEL -> PAUSED.
  - PAUSED: pause_s=0 -> DIM_UP with level MAX_LEVEL-1.
  - DIM_UP: pause_s=1 -> DIM_DOWN with level+1. Else level-1; reaching 0 -> RUN.
  - Reversal is immediate from the current level; no level skips.
- MAX_LEVEL=1 edge: RUN->DIM_DOWN reaches max immediately and must enter PAUSED in the same transition. DIM_UP from level 1 goes to RUN.
- paused and fade_level are registered and change only the cycle after a tick.
- Tick and enable-change on the same cycle: the new enables take effect from that tick. Tick during reset is ignored.

Decomposition:
- Shared package av_pkg:
  - COLOR_W default
  - pixel field positions (OPAQUE_BIT)
  - fade state enum {RUN, DIM_DOWN, PAUSED, DIM_UP}
  - named layer indices LAYER_MENU, LAYER_SCORE, LAYER_STRING1..6, LAYER_COUNT
- Sub-module av_fade_ctrl: synchroniser, tick-driven FSM, and level counter; outputs fade_level and paused.
- Priority select and dimming stay in the top level.

Test Plan:
- Reset, bg=12'h8A4, all layers transparent, blank_in=0 -> pixel=12'h8A4 exactly 3 cycles after inputs. hsync_out/vsync_out/blank_out equal inputs delayed 3.
- Layers 2 and 5 opaque (12'hF00, 12'h0F0), all enabled -> 12'hF00. Set layer_en_in[2]=0 mid-frame -> still 12'hF00 until the next vsync tick, then 12'h0F0.
- Hold pause=1 -> fade_level steps 1..6 on successive ticks, then paused=1. At level 6 a game pixel 12'hFFF outputs 12'h333. The opaque menu layer shows 12'h0FF undimmed.
- pause=1 for 3 ticks then 0 -> levels 1,2,3,2,1,0; state ends RUN. The menu layer is masked again in RUN, showing the next layer or bg.
- blank_in=1 with opaque layers -> pixel=0. Assert reset at fade_level 4 -> the next cycle shows fade_level=0, paused=0, pixel=0, enables=EN_RESET.
- Regression with NUM_LAYERS=2, COLOR_W=5, MAX_LEVEL=1 -> one tick of pause gives PAUSED. Channel 31 at level 1 gives 27.
